// File: rtl/fetchsource_buf.sv
// Source-pixel fetch: one WISHBONE read per source address, pixel + paired dest address into a FWFT FIFO.
// Latency: push in cycle N is visible at the FIFO head in cycle N+1; a reuse hit costs one cycle and no bus read.
// Backpressure: a full FIFO (registered count) blocks stb and pa_next; downstream pops free a slot for the next cycle.
// Optional feature: define FETCHSOURCE_REUSE_EN to build the last-address reuse register.
module fetchsource_buf #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  pa_ready,
    output logic                  pa_next,
    output logic [31:0]           mwb_adr_o,
    output logic                  mwb_cyc_o,
    output logic                  mwb_stb_o,
    output logic [3:0]            mwb_sel_o,
    input  logic                  mwb_ack_i,
    input  logic [31:0]           mwb_dat_i,
    input  logic                  cache_inval,
    output logic [DATA_WIDTH-1:0] fs_data,
    output logic [ADDR_WIDTH-1:0] fs_daddr,
    output logic                  fs_ready,
    input  logic                  fs_next
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_data  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_daddr [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  full;
    logic                  can_push;
    logic                  hit;
    logic                  bus_push;
    logic                  hit_push;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] bus_pixel;
    logic [DATA_WIDTH-1:0] hit_pixel;
    logic [DATA_WIDTH-1:0] push_pixel;
    logic [31:0]           adr_ext;

    assign full      = (count == CW'(FIFO_DEPTH));
    // Reset gates the request so an in-flight read is dropped the moment rst rises.
    assign can_push  = pa_ready & ~full & ~rst;
    assign bus_pixel = mwb_dat_i[DATA_WIDTH-1:0];

    assign mwb_stb_o = can_push & ~hit;
    assign mwb_cyc_o = mwb_stb_o;
    assign mwb_sel_o = 4'hF;
    assign adr_ext   = 32'(s_addr);
    assign mwb_adr_o = adr_ext << 2;

    assign bus_push   = mwb_stb_o & mwb_ack_i;
    assign hit_push   = can_push & hit;
    assign push       = bus_push | hit_push;
    assign pa_next    = push;
    assign push_pixel = hit ? hit_pixel : bus_pixel;

    assign pop      = fs_next & (count != '0);
    assign fs_ready = (count != '0);
    assign fs_data  = mem_data[rd_ptr];
    assign fs_daddr = mem_daddr[rd_ptr];

`ifdef FETCHSOURCE_REUSE_EN
    logic                  reuse_valid;
    logic [ADDR_WIDTH-1:0] reuse_addr;
    logic [DATA_WIDTH-1:0] reuse_data;
    logic                  unused_bits;

    assign hit         = reuse_valid & (s_addr == reuse_addr);
    assign hit_pixel   = reuse_data;
    assign unused_bits = ^mwb_dat_i;

    // Remember the last bus-fetched pixel; invalidation wins over a same-cycle refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reuse_valid <= 1'b0;
            reuse_addr  <= '0;
            reuse_data  <= '0;
        end else begin
            if (bus_push) begin
                reuse_addr <= s_addr;
                reuse_data <= bus_pixel;
            end
            if (cache_inval) begin
                reuse_valid <= 1'b0;
            end else if (bus_push) begin
                reuse_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_bits;

    assign hit         = 1'b0;
    assign hit_pixel   = '0;
    assign unused_bits = ^{mwb_dat_i, cache_inval};
`endif

    // FIFO storage: write the fetched pixel with its destination address at wr_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= push_pixel;
            mem_daddr[wr_ptr] <= d_addr;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count holds on simultaneous push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
